// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        ERR   = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    // Flags a request that must not touch memory: bad funct3, misalignment or out-of-range word.
    function automatic logic req_error(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] mem_words
    );
        logic bad_f3;
        logic misal;
        logic oor;
        if (we) begin
            bad_f3 = (f3 >= 3'b011);
        end else begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: bad_f3 = 1'b0;
                default:                        bad_f3 = 1'b1;
            endcase
        end
        case (f3)
            F3_H, F3_HU: misal = addr[0];
            F3_W:        misal = (addr[1:0] != 2'b00);
            default:     misal = 1'b0;
        endcase
        oor = ({2'b00, addr[31:2]} >= mem_words);
        return bad_f3 | misal | oor;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extraction with sign/zero extension and sub-word store merge.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword of the memory word.
    always_comb begin
        case (byte_off_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            2'd3:    byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (byte_off_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
    end

    // Extend the selected lane to 32 bits.
    always_comb begin
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
            F3_W:    load_data_o = word_i;
            F3_BU:   load_data_o = {24'h000000, byte_s};
            F3_HU:   load_data_o = {16'h0000, half_s};
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Replace the addressed lane of the current word with the store data.
    always_comb begin
        store_word_o = word_i;
        case (funct3_i)
            F3_B: begin
                case (byte_off_i)
                    2'd0:    store_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    store_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    store_word_o[23:16] = wdata_i[7:0];
                    2'd3:    store_word_o[31:24] = wdata_i[7:0];
                    default: store_word_o        = word_i;
                endcase
            end
            F3_H: begin
                if (byte_off_i[1]) begin
                    store_word_o[31:16] = wdata_i[15:0];
                end else begin
                    store_word_o[15:0]  = wdata_i[15:0];
                end
            end
            F3_W:    store_word_o = wdata_i;
            default: store_word_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: valid/ready request in, one-cycle response pulse out,
// drives a word-indexed data memory with read-modify-write for SB/SH.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;
    logic [31:0] mem_a_q;
    logic        mem_we_q;
    logic [31:0] mem_wd_q;

    logic        req_err_s;
    logic [31:0] load_data_s;
    logic [31:0] store_word_s;

    assign req_err_s = req_error(req_we, req_funct3, req_addr, 32'(MEM_WORDS));

    lsu_byte_lane u_lane (
        .word_i      (mem_rd),
        .wdata_i     (wdata_q),
        .byte_off_i  (off_q),
        .funct3_i    (f3_q),
        .load_data_o (load_data_s),
        .store_word_o(store_word_s)
    );

    // Request FSM with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_error_q <= 1'b0;
            mem_a_q     <= 32'h0000_0000;
            mem_we_q    <= 1'b0;
            mem_wd_q    <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0000_0000;
                    rsp_error_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_wd_q    <= 32'h0000_0000;
                    if (req_valid) begin
                        off_q   <= req_addr[1:0];
                        f3_q    <= req_funct3;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        mem_a_q <= {2'b00, req_addr[31:2]};
                        if (req_err_s) begin
                            state_q <= ERR;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            // Full-word store skips the read and writes straight away.
                            state_q  <= WRITE;
                            mem_we_q <= 1'b1;
                            mem_wd_q <= req_wdata;
                        end else begin
                            state_q <= READ;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    if (we_q) begin
                        state_q  <= WRITE;
                        mem_we_q <= 1'b1;
                        mem_wd_q <= store_word_s;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_data_s;
                        rsp_error_q <= 1'b0;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    mem_we_q    <= 1'b0;
                    mem_wd_q    <= 32'h0000_0000;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= 32'h0000_0000;
                    rsp_error_q <= 1'b0;
                end
                ERR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= 32'h0000_0000;
                    rsp_error_q <= 1'b1;
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0000_0000;
                    rsp_error_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0000_0000;
                    rsp_error_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_wd_q    <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Reset gates the write strobe immediately so an in-flight write never lands.
    assign mem_we    = mem_we_q & ~rst;
    assign req_ready = (state_q == IDLE) & ~rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign mem_a     = mem_a_q;
    assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];
    int          we_cnt = 0;
    logic [31:0] last_wd = 32'h0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .mem_a     (mem_a),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    assign mem_rd = (mem_we || (mem_a >= 32'd1024)) ? 32'h0 : mem[mem_a[9:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_a < 32'd1024) mem[mem_a[9:0]] <= mem_wd;
            we_cnt  <= we_cnt + 1;
            last_wd <= mem_wd;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge; returns at the negedge where rsp_valid is seen (or bound expires).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int guard = 0;
        int busy_ready = 0;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 8) begin
            if (req_ready) busy_ready++;
            @(negedge clk);
            lat++;
        end
        if (req_ready) busy_ready++;
        rdata = rsp_rdata;
        err   = rsp_error;
        check_eq("ready_low_while_busy", 32'(busy_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          w0;
        logic [31:0] bb_addr [3];
        logic [2:0]  bb_f3 [3];
        logic [31:0] bb_exp [3];
        int          idx, got, rdy_cnt, cyc, rsp_seen;
        logic        r;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'h0, req_ready}, 32'd0);
        check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        check_eq("rst_error", {31'h0, rsp_error}, 32'd0);
        check_eq("rst_mem_a", mem_a, 32'h0);
        check_eq("rst_mem_we", {31'h0, mem_we}, 32'd0);
        check_eq("rst_mem_wd", mem_wd, 32'h0);
        rst = 1'b0;
        #1 check_eq("ready_after_rst", {31'h0, req_ready}, 32'd1);
        @(negedge clk);

        // Preload through full-word stores.
        do_req(1'b1, F3_W, 32'h70, 32'h0000_0020, rd, er, lat); @(negedge clk);
        do_req(1'b1, F3_W, 32'h78, 32'h1111_2222, rd, er, lat); @(negedge clk);
        do_req(1'b1, F3_W, 32'h7C, 32'h80FF_7F01, rd, er, lat); @(negedge clk);
        do_req(1'b1, F3_W, 32'h84, 32'hCAFE_F00D, rd, er, lat); @(negedge clk);

        w0 = we_cnt;
        do_req(1'b0, F3_W, 32'h70, 32'h0, rd, er, lat);
        check_eq("lw70_lat", 32'(lat), 32'd2);
        check_eq("lw70_data", rd, 32'h0000_0020);
        check_eq("lw70_err", {31'h0, er}, 32'd0);
        check_eq("lw70_mem_a", mem_a, 32'd28);
        check_eq("lw70_no_write", 32'(we_cnt - w0), 32'd0);
        @(negedge clk);

        // Back-to-back loads with req_valid held high.
        bb_addr[0] = 32'h70; bb_f3[0] = F3_W; bb_exp[0] = 32'h0000_0020;
        bb_addr[1] = 32'h7A; bb_f3[1] = F3_H; bb_exp[1] = 32'h0000_1111;
        bb_addr[2] = 32'h7F; bb_f3[2] = F3_B; bb_exp[2] = 32'hFFFF_FF80;
        idx = 0; got = 0; rdy_cnt = 0; cyc = 0;
        req_we = 1'b0; req_funct3 = bb_f3[0]; req_addr = bb_addr[0]; req_valid = 1'b1;
        while (got < 3 && cyc < 40) begin
            if (rsp_valid) begin
                check_eq($sformatf("b2b_rsp%0d", got), rsp_rdata, bb_exp[got]);
                got++;
            end
            r = req_ready && req_valid;
            if (req_ready) rdy_cnt++;
            @(posedge clk);
            #1;
            if (r) begin
                idx++;
                if (idx < 3) begin
                    req_funct3 = bb_f3[idx];
                    req_addr   = bb_addr[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("b2b_count", 32'(got), 32'd3);
        check_eq("b2b_ready_cycles", 32'(rdy_cnt), 32'd3);
        check_eq("b2b_cycles", 32'(cyc), 32'd9);
        @(negedge clk);

        w0 = we_cnt;
        do_req(1'b1, F3_W, 32'h80, 32'hDEAD_BEEF, rd, er, lat);
        check_eq("sw80_lat", 32'(lat), 32'd2);
        check_eq("sw80_rdata", rd, 32'h0);
        check_eq("sw80_writes", 32'(we_cnt - w0), 32'd1);
        check_eq("sw80_wd", last_wd, 32'hDEAD_BEEF);
        @(negedge clk);
        do_req(1'b0, F3_B, 32'h83, 32'h0, rd, er, lat);  check_eq("lb83", rd, 32'hFFFF_FFDE); @(negedge clk);
        do_req(1'b0, F3_BU, 32'h81, 32'h0, rd, er, lat); check_eq("lbu81", rd, 32'h0000_00BE); @(negedge clk);
        do_req(1'b0, F3_H, 32'h82, 32'h0, rd, er, lat);  check_eq("lh82", rd, 32'hFFFF_DEAD); @(negedge clk);
        do_req(1'b0, F3_HU, 32'h80, 32'h0, rd, er, lat); check_eq("lhu80", rd, 32'h0000_BEEF); @(negedge clk);

        w0 = we_cnt;
        do_req(1'b1, F3_B, 32'h81, 32'h1234_5655, rd, er, lat);
        check_eq("sb81_lat", 32'(lat), 32'd3);
        check_eq("sb81_writes", 32'(we_cnt - w0), 32'd1);
        check_eq("sb81_wd", last_wd, 32'hDEAD_55EF);
        @(negedge clk);
        do_req(1'b0, F3_W, 32'h80, 32'h0, rd, er, lat);
        check_eq("lw80_after_sb", rd, 32'hDEAD_55EF);
        @(negedge clk);

        w0 = we_cnt;
        do_req(1'b0, F3_W, 32'h72, 32'h0, rd, er, lat);
        check_eq("lw72_err", {31'h0, er}, 32'd1);
        check_eq("lw72_rdata", rd, 32'h0);
        check_eq("lw72_lat", 32'(lat), 32'd2);
        @(negedge clk);
        do_req(1'b1, F3_H, 32'h81, 32'h0000_FFFF, rd, er, lat);
        check_eq("sh81_err", {31'h0, er}, 32'd1);
        @(negedge clk);
        do_req(1'b0, F3_W, 32'h1000, 32'h0, rd, er, lat);
        check_eq("lw1000_err", {31'h0, er}, 32'd1);
        @(negedge clk);
        do_req(1'b0, 3'b011, 32'h70, 32'h0, rd, er, lat);
        check_eq("ld_f3_011_err", {31'h0, er}, 32'd1);
        @(negedge clk);
        do_req(1'b1, 3'b011, 32'h70, 32'h0, rd, er, lat);
        check_eq("st_f3_011_err", {31'h0, er}, 32'd1);
        check_eq("err_no_writes", 32'(we_cnt - w0), 32'd0);
        @(negedge clk);

        // Reset during the WRITE cycle of SB 0x84.
        w0 = we_cnt;
        req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h84; req_wdata = 32'h0000_00AA;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstw_pending_we", {31'h0, mem_we}, 32'd1);
        check_eq("rstw_pending_wd", mem_wd, 32'hCAFE_F0AA);
        rst = 1'b1;
        #1 check_eq("rstw_we_gated", {31'h0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rstw_ready", {31'h0, req_ready}, 32'd1);
        rsp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check_eq("rstw_no_rsp", 32'(rsp_seen), 32'd0);
        check_eq("rstw_no_write", 32'(we_cnt - w0), 32'd0);
        check_eq("rstw_mem84", mem[33], 32'hCAFE_F00D);
        do_req(1'b0, F3_W, 32'h84, 32'h0, rd, er, lat);
        check_eq("rstw_lw84", rd, 32'hCAFE_F00D);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
